// File: rtl/mem_preloader_if.sv
// Host stream (write/expect in, dump out) plus single-port memory bundle for mem_preloader.
// master = engine side, slave = host/memory side.
interface mem_preloader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  in_valid, in_data, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, out_addr, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, out_addr, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_preloader.sv
// Memory fill/zero/verify/dump engine; writes 1 word/cycle (FILL stalls on in_valid), reads 3 cycles/word.
// Backpressure: FILL/VERIFY wait on in_valid, DUMP holds its beat until out_ready; no timeouts.
module mem_preloader #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 256,
  parameter int LEN_WIDTH    = ADDR_WIDTH + 1,
  parameter int STOP_ON_ERR  = 1,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    length,
  input  logic [DATA_WIDTH-1:0]   fill_value,
  mem_preloader_if.master         bus,
  output logic                    busy,
  output logic                    core_hold,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [DATA_WIDTH-1:0]   err_data,
  output logic [ERRCNT_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAP, RD_HOLD, FINISH} state_t;
  typedef enum logic [1:0] {OP_FILL = 2'b00, OP_ZERO = 2'b01, OP_VERIFY = 2'b10, OP_DUMP = 2'b11} op_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0]  MAX_LEN   = LEN_WIDTH'(MEM_DEPTH);
  localparam logic [LEN_WIDTH-1:0]  ONE_LEN   = LEN_WIDTH'(1);

  state_t                state, state_nxt;
  op_t                   op;
  logic [ADDR_WIDTH-1:0] addr, base_mod;
  logic [LEN_WIDTH-1:0]  remaining, len_clamp;
  logic [DATA_WIDTH-1:0] fill_q, rbuf;
  logic                  load, wr_fire, adv, cmp_fire, mismatch, last;

  function automatic logic [ADDR_WIDTH-1:0] wrap(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  generate
    if (MEM_DEPTH >= (1 << ADDR_WIDTH)) begin : g_full_span
      assign base_mod = base_addr;
    end else begin : g_mod_span
      assign base_mod = base_addr % ADDR_WIDTH'(MEM_DEPTH);
    end
  endgenerate

  assign len_clamp = (length > MAX_LEN) ? MAX_LEN : length;
  assign last      = (remaining == ONE_LEN);
  assign busy      = (state == WR) || (state == RD_ISSUE) || (state == RD_CAP) || (state == RD_HOLD);
  assign core_hold = busy;
  assign done      = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    wr_fire       = 1'b0;
    adv           = 1'b0;
    cmp_fire      = 1'b0;
    mismatch      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_addr  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (len_clamp == '0) state_nxt = FINISH;
          else if (mode[1])    state_nxt = RD_ISSUE;
          else                 state_nxt = WR;
        end
      end
      WR: begin
        if (op == OP_FILL) begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            wr_fire = 1'b1;
            adv     = 1'b1;
            if (last) state_nxt = FINISH;
          end
        end else begin
          wr_fire = 1'b1;
          adv     = 1'b1;
          if (last) state_nxt = FINISH;
        end
      end
      RD_ISSUE: state_nxt = RD_CAP;
      RD_CAP:   state_nxt = RD_HOLD;
      RD_HOLD: begin
        if (op == OP_VERIFY) begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            cmp_fire = 1'b1;
            mismatch = (bus.in_data != rbuf);
            if (mismatch && (STOP_ON_ERR != 0)) begin
              state_nxt = FINISH;
            end else begin
              adv       = 1'b1;
              state_nxt = last ? FINISH : RD_ISSUE;
            end
          end
        end else begin
          bus.out_valid = 1'b1;
          bus.out_data  = rbuf;
          bus.out_addr  = addr;
          if (bus.out_ready) begin
            adv       = 1'b1;
            state_nxt = last ? FINISH : RD_ISSUE;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op            <= OP_FILL;
      addr          <= '0;
      remaining     <= '0;
      fill_q        <= '0;
      rbuf          <= '0;
      error         <= 1'b0;
      err_addr      <= '0;
      err_data      <= '0;
      err_count     <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (load) begin
        op        <= op_t'(mode);
        addr      <= base_mod;
        remaining <= len_clamp;
        fill_q    <= fill_value;
        error     <= 1'b0;
        err_addr  <= '0;
        err_data  <= '0;
        err_count <= '0;
      end
      if (wr_fire) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= addr;
        bus.mem_wdata <= (op == OP_FILL) ? bus.in_data : fill_q;
      end
      // Present the read address on entry to RD_ISSUE so read data is valid during RD_CAP.
      if (state_nxt == RD_ISSUE) bus.mem_addr <= load ? base_mod : wrap(addr);
      if (adv) begin
        addr      <= wrap(addr);
        remaining <= remaining - ONE_LEN;
      end
      if (state == RD_CAP) rbuf <= bus.mem_rdata;
      if (cmp_fire && mismatch) begin
        if (~&err_count) err_count <= err_count + ERRCNT_WIDTH'(1);
        if (!error) begin
          error    <= 1'b1;
          err_addr <= addr;
          err_data <= rbuf;
        end
      end
    end
  end

endmodule
